// File: rtl/line_scaler.sv
// line_scaler: ping-pong line buffer with 2x horizontal pixel doubling and scanline darkening.
module line_scaler #(
  parameter int PIX_W  = 15,
  parameter int LINE_W = 256,
  parameter int DIV    = 3,
  parameter int RX_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] inputpixel,
  input  logic             reset_frame,
  input  logic             reset_line,
  input  logic [RX_W-1:0]  read_x,
  input  logic             read_odd,
  input  logic             scanline_en,
  output logic [PIX_W-1:0] outpixel,
  output logic             line_short
);
  localparam int CH_W = PIX_W / 3;
  localparam int AW   = $clog2(LINE_W);
  localparam int FW   = $clog2(DIV);
  logic [PIX_W-1:0] mem [2*LINE_W];
  logic [FW-1:0]    frac;
  logic [AW:0]      write_x;
  logic             wr_bank;
  logic [RX_W-1:0]  sx;
  logic             we, blank, last_phase, s1_odd, s1_sl, s1_blank;
  logic [PIX_W-1:0] s1_pix, dark;
  assign sx         = read_x >> 1;
  assign blank      = 32'(sx) >= LINE_W;
  assign last_phase = frac == FW'(DIV - 1);
  assign we         = last_phase && write_x < (AW+1)'(LINE_W) && !reset && !reset_frame && !reset_line;
  always_comb begin
    dark = '0;
    for (int c = 0; c < 3; c++) dark[c*CH_W +: CH_W] = s1_pix[c*CH_W +: CH_W] >> 1;
  end
  // Reads always target the opposite bank, so a concurrent write can never disturb them.
  always_ff @(posedge clk)
    if (we) mem[{wr_bank, write_x[AW-1:0]}] <= inputpixel;
  always_ff @(posedge clk) begin
    if (reset) begin
      frac       <= '0;
      write_x    <= (AW+1)'(LINE_W);
      wr_bank    <= 1'b0;
      line_short <= 1'b0;
      s1_pix     <= '0;
      s1_odd     <= 1'b0;
      s1_sl      <= 1'b0;
      s1_blank   <= 1'b0;
      outpixel   <= '0;
    end else begin
      line_short <= !reset_frame && reset_line && write_x != '0 && write_x < (AW+1)'(LINE_W);
      if (reset_frame || reset_line) begin
        frac    <= '0;
        write_x <= '0;
        wr_bank <= reset_frame ? 1'b0 : ~wr_bank;
      end else begin
        frac <= last_phase ? '0 : frac + 1'b1;
        if (we) write_x <= write_x + 1'b1;
      end
      s1_pix   <= mem[{~wr_bank, sx[AW-1:0]}];
      s1_odd   <= read_odd;
      s1_sl    <= scanline_en;
      s1_blank <= blank;
      outpixel <= s1_blank ? '0 : (s1_sl && s1_odd) ? dark : s1_pix;
    end
  end
endmodule

// File: tb/tb_line_scaler.sv
// tb_line_scaler: directed tests of line_scaler with default parameters.
module tb_line_scaler;
  logic        clk = 1'b0;
  logic        reset = 1'b1, reset_frame = 1'b0, reset_line = 1'b0;
  logic        read_odd = 1'b0, scanline_en = 1'b0, line_short;
  logic [14:0] inputpixel = '0, outpixel, v;
  logic [9:0]  read_x = '0;
  int errors = 0, checks = 0;

  line_scaler dut (
    .clk(clk), .reset(reset), .inputpixel(inputpixel), .reset_frame(reset_frame),
    .reset_line(reset_line), .read_x(read_x), .read_odd(read_odd),
    .scanline_en(scanline_en), .outpixel(outpixel), .line_short(line_short)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task strobe;
    reset_line = 1'b1;
    tick;
    reset_line = 1'b0;
  endtask

  // Starts a new line with a reset_line strobe, then writes n pixels (3 clocks each).
  // With chk set, also reads column 2*i during pixel i and expects exp_rd.
  task fill(input logic [14:0] base, input int n, input bit inc, input bit chk, input logic [14:0] exp_rd);
    strobe;
    for (int i = 0; i < n; i++) begin
      inputpixel = inc ? 15'(base + 15'(i)) : base;
      read_x = 10'(2 * (i % 256));
      tick; tick; tick;
      if (chk) begin
        checks++;
        if (outpixel !== exp_rd) begin
          errors++;
          $display("FAIL pingpong_during_write col=%0d got=%h exp=%h", i, outpixel, exp_rd);
        end
      end
    end
  endtask

  task rd(input logic [9:0] x, input bit odd, input bit sl, output logic [14:0] r);
    read_x = x; read_odd = odd; scanline_en = sl;
    tick; tick;
    r = outpixel;
    read_odd = 1'b0; scanline_en = 1'b0;
  endtask

  task test_reset;
    reset = 1'b1;
    tick; tick; tick;
    checks++; if (outpixel !== 15'h0) begin errors++; $display("FAIL reset_outpixel got=%h exp=0", outpixel); end
    checks++; if (line_short !== 1'b0) begin errors++; $display("FAIL reset_line_short got=%b exp=0", line_short); end
    checks++; if (dut.write_x !== 9'd256) begin errors++; $display("FAIL reset_write_x got=%0d exp=256", dut.write_x); end
    checks++; if (dut.wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got=%b exp=0", dut.wr_bank); end
    reset = 1'b0;
  endtask

  task test_doubling;
    logic [9:0]  xs [5] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd511};
    logic [14:0] es [5] = '{15'h1, 15'h1, 15'h2, 15'h2, 15'h100};
    fill(15'h1, 256, 1'b1, 1'b0, 15'h0);
    strobe;
    checks++; if (line_short !== 1'b0) begin errors++; $display("FAIL full_line_short got=%b exp=0", line_short); end
    for (int k = 0; k < 5; k++) begin
      rd(xs[k], 1'b0, 1'b0, v);
      checks++; if (v !== es[k]) begin errors++; $display("FAIL doubling x=%0d got=%h exp=%h", xs[k], v, es[k]); end
    end
    rd(10'd0, 1'b0, 1'b0, v);
    read_x = 10'd4;
    tick;
    checks++; if (outpixel !== 15'h1) begin errors++; $display("FAIL latency_early got=%h exp=0001", outpixel); end
    tick;
    checks++; if (outpixel !== 15'h3) begin errors++; $display("FAIL latency_two got=%h exp=0003", outpixel); end
  endtask

  task test_scanline;
    fill(15'h7FFF, 256, 1'b0, 1'b0, 15'h0);
    strobe;
    rd(10'd10, 1'b1, 1'b1, v);
    checks++; if (v !== 15'h3DEF) begin errors++; $display("FAIL scan_dark got=%h exp=3DEF", v); end
    rd(10'd10, 1'b0, 1'b1, v);
    checks++; if (v !== 15'h7FFF) begin errors++; $display("FAIL scan_even got=%h exp=7FFF", v); end
    rd(10'd10, 1'b1, 1'b0, v);
    checks++; if (v !== 15'h7FFF) begin errors++; $display("FAIL scan_disabled got=%h exp=7FFF", v); end
    fill(15'h1234, 256, 1'b0, 1'b0, 15'h0);
    strobe;
    rd(10'd77, 1'b1, 1'b1, v);
    checks++; if (v !== 15'h090A) begin errors++; $display("FAIL scan_mixed got=%h exp=090A", v); end
  endtask

  task test_blank;
    rd(10'd512, 1'b0, 1'b0, v);
    checks++; if (v !== 15'h0) begin errors++; $display("FAIL blank_512 got=%h exp=0", v); end
    rd(10'd1023, 1'b1, 1'b1, v);
    checks++; if (v !== 15'h0) begin errors++; $display("FAIL blank_1023_dark got=%h exp=0", v); end
    rd(10'd511, 1'b0, 1'b0, v);
    checks++; if (v !== 15'h1234) begin errors++; $display("FAIL blank_edge_511 got=%h exp=1234", v); end
  endtask

  task test_pingpong;
    fill(15'h1111, 256, 1'b0, 1'b0, 15'h0);
    fill(15'h2222, 256, 1'b0, 1'b1, 15'h1111);
    strobe;
    rd(10'd0, 1'b0, 1'b0, v);
    checks++; if (v !== 15'h2222) begin errors++; $display("FAIL pingpong_after_swap x=0 got=%h exp=2222", v); end
    rd(10'd300, 1'b0, 1'b0, v);
    checks++; if (v !== 15'h2222) begin errors++; $display("FAIL pingpong_after_swap x=300 got=%h exp=2222", v); end
  endtask

  task test_short;
    fill(15'h0055, 100, 1'b0, 1'b0, 15'h0);
    strobe;
    checks++; if (line_short !== 1'b1) begin errors++; $display("FAIL short_pulse got=%b exp=1", line_short); end
    tick;
    checks++; if (line_short !== 1'b0) begin errors++; $display("FAIL short_one_cycle got=%b exp=0", line_short); end
    tick;
    checks++; if (line_short !== 1'b0) begin errors++; $display("FAIL short_empty_line got=%b exp=0", line_short); end
    fill(15'h0AAA, 50, 1'b0, 1'b0, 15'h0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick; tick; tick; tick;
    checks++; if (dut.write_x !== 9'd256) begin errors++; $display("FAIL abort_write_x got=%0d exp=256", dut.write_x); end
    strobe;
    checks++; if (line_short !== 1'b0) begin errors++; $display("FAIL abort_no_short got=%b exp=0", line_short); end
  endtask

  task test_coincident;
    fill(15'h0333, 100, 1'b0, 1'b0, 15'h0);
    reset_frame = 1'b1; reset_line = 1'b1;
    tick;
    reset_frame = 1'b0; reset_line = 1'b0;
    checks++; if (dut.wr_bank !== 1'b0) begin errors++; $display("FAIL coinc_wr_bank got=%b exp=0", dut.wr_bank); end
    checks++; if (dut.write_x !== 9'd0) begin errors++; $display("FAIL coinc_write_x got=%0d exp=0", dut.write_x); end
    checks++; if (line_short !== 1'b0) begin errors++; $display("FAIL coinc_line_short got=%b exp=0", line_short); end
    strobe;
    checks++; if (dut.wr_bank !== 1'b1) begin errors++; $display("FAIL toggle_wr_bank got=%b exp=1", dut.wr_bank); end
    reset_frame = 1'b1;
    tick;
    reset_frame = 1'b0;
    checks++; if (dut.wr_bank !== 1'b0) begin errors++; $display("FAIL frame_force_bank got=%b exp=0", dut.wr_bank); end
  endtask

  initial begin
    test_reset;
    test_doubling;
    test_scanline;
    test_blank;
    test_pingpong;
    test_short;
    test_coincident;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
